// File: rtl/decoder_if.sv
// Bus bundle for the 2-to-4 decoder: select/enable inputs and registered decode outputs.
interface decoder_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             a;
  logic             b;
  logic             q0;
  logic             q1;
  logic             q2;
  logic             q3;
  logic             valid;
  logic             changed;
  logic [CNT_W-1:0] evt_cnt;

  modport master (
    output en, a, b,
    input  q0, q1, q2, q3, valid, changed, evt_cnt
  );

  modport slave (
    input  en, a, b,
    output q0, q1, q2, q3, valid, changed, evt_cnt
  );
endinterface

// File: rtl/decoder.sv
// Registered 2-to-4 one-hot decoder with change detect and a saturating decode-event counter.
module decoder #(
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  decoder_if.slave  bus
);

  logic [1:0]       w_idx;
  logic [3:0]       r_q;
  logic [1:0]       r_idx;
  logic             r_valid;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;

  assign w_idx = {bus.a, bus.b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= 4'b0000;
      r_idx     <= 2'b00;
      r_valid   <= 1'b0;
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else if (bus.en) begin
      r_q       <= 4'b0001 << w_idx;
      r_idx     <= w_idx;
      r_valid   <= 1'b1;
      // The first decode after reset has no prior index to differ from.
      r_changed <= r_valid && (w_idx != r_idx);
      if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_changed <= 1'b0;
    end
  end

  assign bus.q0      = r_q[0];
  assign bus.q1      = r_q[1];
  assign bus.q2      = r_q[2];
  assign bus.q3      = r_q[3];
  assign bus.valid   = r_valid;
  assign bus.changed = r_changed;
  assign bus.evt_cnt = r_cnt;

endmodule

// File: tb/tb_decoder.sv
// Directed bench for decoder: scoreboarded expectations, plus a CNT_W=2 instance for saturation.
module tb_decoder;

  typedef struct packed {
    logic [3:0] q;
    logic       valid;
    logic       changed;
    logic [7:0] cnt;
    logic [1:0] cnt2;
  } exp_t;

  logic clk;
  logic rst;

  decoder_if #(.CNT_W(8)) bus ();
  decoder_if #(.CNT_W(2)) bus2 ();

  decoder #(.CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  decoder #(.CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  assign bus2.en = bus.en;
  assign bus2.a  = bus.a;
  assign bus2.b  = bus.b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;

  logic [3:0] m_q;
  logic [1:0] m_idx;
  logic       m_valid;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_q     = 4'b0000;
    m_idx   = 2'b00;
    m_valid = 1'b0;
    m_cnt   = 8'd0;
    m_cnt2  = 2'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_q"},       {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, 32'd0);
    check({tag, "_valid"},   {31'd0, bus.valid},   32'd0);
    check({tag, "_changed"}, {31'd0, bus.changed}, 32'd0);
    check({tag, "_cnt"},     {24'd0, bus.evt_cnt}, 32'd0);
    check({tag, "_cnt2"},    {30'd0, bus2.evt_cnt}, 32'd0);
  endtask

  task automatic step(input string tag, input logic e, input logic ia, input logic ib);
    exp_t       ex;
    logic [1:0] idx;
    @(negedge clk);
    bus.en = e;
    bus.a  = ia;
    bus.b  = ib;
    ex.changed = 1'b0;
    if (e) begin
      idx        = {ia, ib};
      ex.changed = m_valid && (idx != m_idx);
      m_q        = 4'b0001 << idx;
      m_idx      = idx;
      m_valid    = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
    end
    ex.q     = m_q;
    ex.valid = m_valid;
    ex.cnt   = m_cnt;
    ex.cnt2  = m_cnt2;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    check({tag, "_sb_depth"}, sb_q.size(), 32'd1);
    if (sb_q.size() != 0) begin
      ex = sb_q.pop_front();
      check({tag, "_q"},       {28'd0, bus.q3, bus.q2, bus.q1, bus.q0}, {28'd0, ex.q});
      check({tag, "_valid"},   {31'd0, bus.valid},    {31'd0, ex.valid});
      check({tag, "_changed"}, {31'd0, bus.changed},  {31'd0, ex.changed});
      check({tag, "_cnt"},     {24'd0, bus.evt_cnt},  {24'd0, ex.cnt});
      check({tag, "_cnt2"},    {30'd0, bus2.evt_cnt}, {30'd0, ex.cnt2});
    end
  endtask

  // Assert reset between clock edges, hold it across an enabled edge, release on a falling edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero({tag, "_async"});
    bus.en = 1'b1;
    bus.a  = 1'b1;
    bus.b  = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero({tag, "_held"});
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    model_reset();
  endtask

  initial begin
    rst    = 1'b1;
    bus.en = 1'b0;
    bus.a  = 1'b0;
    bus.b  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b0;

    step("first01", 1'b1, 1'b0, 1'b1);
    step("next10",  1'b1, 1'b1, 1'b0);
    async_reset("rst1");

    // Full truth table
    step("tt00", 1'b1, 1'b0, 1'b0);
    step("tt01", 1'b1, 1'b0, 1'b1);
    step("tt10", 1'b1, 1'b1, 1'b0);
    step("tt11", 1'b1, 1'b1, 1'b1);

    // Hold with en low while a/b toggle
    step("hold_set10", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("hold", 1'b0, i[0], ~i[0]);
    end

    // Repeated index
    for (int i = 0; i < 3; i++) begin
      step("rep11", 1'b1, 1'b1, 1'b1);
    end

    // Mid-run reset discards history
    step("mid_a", 1'b1, 1'b0, 1'b0);
    step("mid_b", 1'b1, 1'b1, 1'b1);
    step("mid_c", 1'b1, 1'b1, 1'b0);
    async_reset("rst2");
    step("post01", 1'b1, 1'b0, 1'b1);

    // Saturation of the 2-bit counter, then random traffic
    async_reset("rst3");
    for (int i = 0; i < 6; i++) begin
      step("sat", 1'b1, i[1], i[0]);
    end
    for (int i = 0; i < 300; i++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
